// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg
// Shared types and constants for the LEGv8 data-memory access sequencer.
//   mac_state_t : sequencer states (IDLE, REQ, DONE, ERR)
//   XFER_BYTE   : transfer-size encoding for a single byte (LDURB/STURB)
//   XFER_DWORD  : transfer-size encoding for a doubleword (LDUR/STUR)
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } mac_state_t;

    localparam logic [3:0] XFER_BYTE  = 4'b0001;
    localparam logic [3:0] XFER_DWORD = 4'b1000;

endpackage

// File: rtl/access_timer.sv
// access_timer
// Clearable, enabled up-counter that flags when it has reached TIMEOUT-1.
// Used to bound the number of cycles a memory request may wait for an ack.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset
//   clr_i : synchronous clear (has priority over enable)
//   en_i  : count enable
//   tc_o  : terminal count, high while the count equals TIMEOUT-1
module access_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;

    // Counter register: clear wins over enable so a fresh access always
    // starts from zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign tc_o = (cnt_q == LAST);

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Multi-cycle data-memory access sequencer for the LEGv8 execute stage.
// Accepts a load/store from decode, runs a req/ack handshake with a
// variable-latency data memory, stalls the PC until the access retires,
// zero-extends byte loads, rejects illegal requests and bounds every
// access with a timeout.
// Ports:
//   clk, reset          : clock and asynchronous active-high reset
//   mem_read, mem_write : load / store in execute
//   xfer_size, ldurb    : transfer size in bytes, byte-load zero-extend flag
//   addr, wdata         : effective address and store data
//   stall               : hold PC / instruction this cycle
//   rdata, done         : load result and one-cycle retire pulse
//   err, err_sticky     : one-cycle abort pulse and its sticky record
//   dm_req, dm_we, dm_addr, dm_wdata, dm_size : registered memory request
//   dm_ack, dm_rdata    : memory completion and read data
module mem_access_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [3:0]        xfer_size,
    input  logic              ldurb,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              stall,
    output logic [DATA_W-1:0] rdata,
    output logic              done,
    output logic              err,
    output logic              err_sticky,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    output logic [3:0]        dm_size,
    input  logic              dm_ack,
    input  logic [DATA_W-1:0] dm_rdata
);

    import mem_ctrl_pkg::*;

    mac_state_t        state_q, state_d;
    logic              req_any, size_ok, legal, accept;
    logic              timer_clr, timer_en, timer_tc;
    logic              dm_req_q, dm_we_q, ldurb_q, err_sticky_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;
    logic [3:0]        size_q;

    // A doubleword must be 8-byte aligned; a byte may sit anywhere.
    assign req_any = mem_read | mem_write;
    assign size_ok = (xfer_size == XFER_BYTE) ||
                     ((xfer_size == XFER_DWORD) && (addr[2:0] == 3'b000));
    assign legal   = (mem_read ^ mem_write) && size_ok;
    assign accept  = (state_q == IDLE) && req_any && legal;

    access_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clr_i (timer_clr),
        .en_i  (timer_en),
        .tc_o  (timer_tc)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. An ack is checked before the timeout so that an
    // ack in the last allowed REQ cycle still completes the access.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    state_d = legal ? REQ : ERR;
                end
            end
            REQ: begin
                if (dm_ack) begin
                    state_d = DONE;
                end else if (timer_tc) begin
                    state_d = ERR;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode. The timer is held clear while idle so every access
    // starts counting from zero in its first REQ cycle.
    always_comb begin
        stall     = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        rdata     = '0;
        timer_clr = 1'b0;
        timer_en  = 1'b0;
        case (state_q)
            IDLE: begin
                stall     = req_any;
                timer_clr = 1'b1;
            end
            REQ: begin
                stall    = 1'b1;
                timer_en = ~dm_ack;
            end
            DONE: begin
                done  = 1'b1;
                rdata = rdata_q;
            end
            ERR: begin
                err = 1'b1;
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

    // Request latches and memory-side outputs. dm_req/dm_we follow the
    // next state so they are already registered in the first REQ cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dm_req_q     <= 1'b0;
            dm_we_q      <= 1'b0;
            ldurb_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            size_q       <= '0;
            rdata_q      <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            dm_req_q <= (state_d == REQ);
            if (state_d != REQ) begin
                dm_we_q <= 1'b0;
            end else if (accept) begin
                dm_we_q <= mem_write;
            end
            if (accept) begin
                addr_q  <= addr;
                wdata_q <= wdata;
                size_q  <= xfer_size;
                ldurb_q <= ldurb;
            end
            // Stores retire with a zero result; byte loads are zero-extended.
            if ((state_q == REQ) && dm_ack) begin
                if (dm_we_q) begin
                    rdata_q <= '0;
                end else if (ldurb_q) begin
                    rdata_q <= {{(DATA_W-8){1'b0}}, dm_rdata[7:0]};
                end else begin
                    rdata_q <= dm_rdata;
                end
            end
            if (state_d == ERR) begin
                err_sticky_q <= 1'b1;
            end
        end
    end

    assign dm_req     = dm_req_q;
    assign dm_we      = dm_we_q;
    assign dm_addr    = addr_q;
    assign dm_wdata   = wdata_q;
    assign dm_size    = size_q;
    assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl
// Directed testbench for mem_access_ctrl with TIMEOUT=16. Inputs change just
// after a falling edge and outputs are sampled 1 time unit later, well away
// from the rising (active) edge.
module tb_mem_access_ctrl;

    logic        clk;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  xfer_size;
    logic        ldurb;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        stall;
    logic [63:0] rdata;
    logic        done;
    logic        err;
    logic        err_sticky;
    logic        dm_req;
    logic        dm_we;
    logic [63:0] dm_addr;
    logic [63:0] dm_wdata;
    logic [3:0]  dm_size;
    logic        dm_ack;
    logic [63:0] dm_rdata;

    int total = 0;
    int bad   = 0;

    mem_access_ctrl #(
        .TIMEOUT(16),
        .ADDR_W (64),
        .DATA_W (64)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .xfer_size  (xfer_size),
        .ldurb      (ldurb),
        .addr       (addr),
        .wdata      (wdata),
        .stall      (stall),
        .rdata      (rdata),
        .done       (done),
        .err        (err),
        .err_sticky (err_sticky),
        .dm_req     (dm_req),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_size    (dm_size),
        .dm_ack     (dm_ack),
        .dm_rdata   (dm_rdata)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one instruction through the sequencer and measures what it did.
    // ack_at = REQ cycle (1-based) in which dm_ack is raised, 0 = never.
    // With toggle set, decode inputs are scrambled after the accept cycle.
    task automatic applyStimulus(
        input  logic        rd,
        input  logic        wr,
        input  logic [3:0]  sz,
        input  logic        lb,
        input  logic [63:0] a,
        input  logic [63:0] wd,
        input  int          ack_at,
        input  logic [63:0] rdat,
        input  logic        toggle,
        output int          n_stall,
        output int          n_req,
        output int          n_done,
        output int          n_err,
        output logic [63:0] r_seen,
        output logic [63:0] addr_seen,
        output logic [63:0] wdata_seen,
        output logic        we_seen,
        output logic [3:0]  size_seen
    );
        logic fin;
        n_stall = 0; n_req = 0; n_done = 0; n_err = 0;
        r_seen = '0; addr_seen = '0; wdata_seen = '0; we_seen = 1'b0; size_seen = '0;
        fin = 1'b0;
        mem_read = rd; mem_write = wr; xfer_size = sz; ldurb = lb;
        addr = a; wdata = wd;
        for (int cyc = 0; cyc < 40 && !fin; cyc++) begin
            dm_ack = 1'b0;
            if (cyc > 0) begin
                if (toggle) begin
                    mem_read = 1'b1; mem_write = 1'b1; xfer_size = 4'b0100;
                    ldurb = ~lb; addr = ~a; wdata = ~wd;
                end else begin
                    mem_read = 1'b0; mem_write = 1'b0;
                end
            end
            #1;
            if (stall) n_stall++;
            if (dm_req) begin
                n_req++;
                addr_seen = dm_addr; wdata_seen = dm_wdata;
                we_seen = dm_we; size_seen = dm_size;
                if (n_req == ack_at) begin
                    dm_ack = 1'b1;
                    dm_rdata = rdat;
                end
            end
            if (done) begin n_done++; r_seen = rdata; end
            if (err)  begin n_err++;  r_seen = rdata; end
            if (done || err) begin
                mem_read = 1'b0; mem_write = 1'b0;
                fin = 1'b1;
            end
            @(negedge clk);
        end
        dm_ack = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL reset_stall: got %b want 0", stall); end
        total++; if (done !== 1'b0 || err !== 1'b0) begin bad++; $display("[TB] FAIL reset_done_err: got %b%b want 00", done, err); end
        total++; if (err_sticky !== 1'b0) begin bad++; $display("[TB] FAIL reset_sticky: got %b want 0", err_sticky); end
        total++; if (dm_req !== 1'b0 || dm_we !== 1'b0) begin bad++; $display("[TB] FAIL reset_req_we: got %b%b want 00", dm_req, dm_we); end
        total++; if (dm_addr !== 64'd0 || dm_wdata !== 64'd0 || dm_size !== 4'd0) begin bad++; $display("[TB] FAIL reset_dm_fields: got %h %h %h want 0 0 0", dm_addr, dm_wdata, dm_size); end
        total++; if (rdata !== 64'd0) begin bad++; $display("[TB] FAIL reset_rdata: got %h want 0", rdata); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_ldur;
        int ns, nr, nd, ne; logic [63:0] rs, as, ws; logic we; logic [3:0] sz;
        applyStimulus(1'b1, 1'b0, 4'b1000, 1'b0, 64'h10, 64'h0, 3, 64'hDEADBEEF_CAFEF00D, 1'b0,
                      ns, nr, nd, ne, rs, as, ws, we, sz);
        total++; if (ns !== 4) begin bad++; $display("[TB] FAIL ldur_stall: got %0d want 4", ns); end
        total++; if (nr !== 3) begin bad++; $display("[TB] FAIL ldur_req_cycles: got %0d want 3", nr); end
        total++; if (nd !== 1 || ne !== 0) begin bad++; $display("[TB] FAIL ldur_done_err: got %0d/%0d want 1/0", nd, ne); end
        total++; if (rs !== 64'hDEADBEEF_CAFEF00D) begin bad++; $display("[TB] FAIL ldur_rdata: got %h want deadbeefcafef00d", rs); end
        total++; if (we !== 1'b0 || sz !== 4'b1000 || as !== 64'h10) begin bad++; $display("[TB] FAIL ldur_dm_fields: got we=%b size=%h addr=%h want 0 8 10", we, sz, as); end
    endtask

    task automatic test_ldurb;
        int ns, nr, nd, ne; logic [63:0] rs, as, ws; logic we; logic [3:0] sz;
        applyStimulus(1'b1, 1'b0, 4'b0001, 1'b1, 64'h13, 64'h0, 1, 64'h11223344_556677AB, 1'b0,
                      ns, nr, nd, ne, rs, as, ws, we, sz);
        total++; if (ns !== 2) begin bad++; $display("[TB] FAIL ldurb_stall: got %0d want 2", ns); end
        total++; if (nd !== 1 || ne !== 0) begin bad++; $display("[TB] FAIL ldurb_done_err: got %0d/%0d want 1/0", nd, ne); end
        total++; if (rs !== 64'h00000000_000000AB) begin bad++; $display("[TB] FAIL ldurb_rdata: got %h want 00000000000000ab", rs); end
        total++; if (sz !== 4'b0001 || as !== 64'h13) begin bad++; $display("[TB] FAIL ldurb_dm_fields: got size=%h addr=%h want 1 13", sz, as); end
    endtask

    task automatic test_stur_toggle;
        int ns, nr, nd, ne; logic [63:0] rs, as, ws; logic we; logic [3:0] sz;
        applyStimulus(1'b0, 1'b1, 4'b1000, 1'b0, 64'h8, 64'h1234, 3, 64'hFFFFFFFF_FFFFFFFF, 1'b1,
                      ns, nr, nd, ne, rs, as, ws, we, sz);
        total++; if (ns !== 4) begin bad++; $display("[TB] FAIL stur_stall: got %0d want 4", ns); end
        total++; if (nd !== 1 || ne !== 0) begin bad++; $display("[TB] FAIL stur_done_err: got %0d/%0d want 1/0", nd, ne); end
        total++; if (rs !== 64'd0) begin bad++; $display("[TB] FAIL stur_rdata: got %h want 0", rs); end
        total++; if (we !== 1'b1 || ws !== 64'h1234) begin bad++; $display("[TB] FAIL stur_we_wdata: got we=%b wdata=%h want 1 1234", we, ws); end
        total++; if (as !== 64'h8 || sz !== 4'b1000) begin bad++; $display("[TB] FAIL stur_addr_size: got addr=%h size=%h want 8 8", as, sz); end
    endtask

    task automatic test_illegal;
        int ns, nr, nd, ne; logic [63:0] rs, as, ws; logic we; logic [3:0] sz;
        logic        rd_v [3] = '{1'b0, 1'b1, 1'b1};
        logic        wr_v [3] = '{1'b1, 1'b1, 1'b0};
        logic [3:0]  sz_v [3] = '{4'b1000, 4'b1000, 4'b0100};
        logic [63:0] ad_v [3] = '{64'h4, 64'h18, 64'h20};
        for (int i = 0; i < 3; i++) begin
            applyStimulus(rd_v[i], wr_v[i], sz_v[i], 1'b0, ad_v[i], 64'h55, 1, 64'h77, 1'b0,
                          ns, nr, nd, ne, rs, as, ws, we, sz);
            total++; if (ns !== 1) begin bad++; $display("[TB] FAIL illegal%0d_stall: got %0d want 1", i, ns); end
            total++; if (nr !== 0) begin bad++; $display("[TB] FAIL illegal%0d_req: got %0d want 0", i, nr); end
            total++; if (ne !== 1 || nd !== 0) begin bad++; $display("[TB] FAIL illegal%0d_err_done: got %0d/%0d want 1/0", i, ne, nd); end
            #1;
            total++; if (err_sticky !== 1'b1) begin bad++; $display("[TB] FAIL illegal%0d_sticky: got %b want 1", i, err_sticky); end
            @(negedge clk);
        end
    endtask

    task automatic test_ack_race;
        int ns, nr, nd, ne; logic [63:0] rs, as, ws; logic we; logic [3:0] sz;
        applyStimulus(1'b1, 1'b0, 4'b1000, 1'b0, 64'h28, 64'h0, 16, 64'h01234567_89ABCDEF, 1'b0,
                      ns, nr, nd, ne, rs, as, ws, we, sz);
        total++; if (nr !== 16 || ns !== 17) begin bad++; $display("[TB] FAIL race_cycles: got req=%0d stall=%0d want 16 17", nr, ns); end
        total++; if (nd !== 1 || ne !== 0) begin bad++; $display("[TB] FAIL race_done_err: got %0d/%0d want 1/0", nd, ne); end
        total++; if (rs !== 64'h01234567_89ABCDEF) begin bad++; $display("[TB] FAIL race_rdata: got %h want 0123456789abcdef", rs); end
        total++; if (err_sticky !== 1'b1) begin bad++; $display("[TB] FAIL race_sticky_held: got %b want 1", err_sticky); end
    endtask

    task automatic test_timeout;
        int ns, nr, nd, ne; logic [63:0] rs, as, ws; logic we; logic [3:0] sz;
        applyStimulus(1'b1, 1'b0, 4'b1000, 1'b0, 64'h30, 64'h0, 0, 64'h0, 1'b0,
                      ns, nr, nd, ne, rs, as, ws, we, sz);
        total++; if (nr !== 16) begin bad++; $display("[TB] FAIL timeout_req: got %0d want 16", nr); end
        total++; if (ns !== 17) begin bad++; $display("[TB] FAIL timeout_stall: got %0d want 17", ns); end
        total++; if (ne !== 1 || nd !== 0) begin bad++; $display("[TB] FAIL timeout_err_done: got %0d/%0d want 1/0", ne, nd); end
        total++; if (rs !== 64'd0) begin bad++; $display("[TB] FAIL timeout_rdata: got %h want 0", rs); end
        #1;
        total++; if (stall !== 1'b0 || dm_req !== 1'b0 || err !== 1'b0) begin bad++; $display("[TB] FAIL timeout_idle: got stall=%b req=%b err=%b want 000", stall, dm_req, err); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [5:0] req_v, stall_v, done_v;
        req_v = '0; stall_v = '0; done_v = '0;
        mem_read = 1'b1; mem_write = 1'b0; xfer_size = 4'b1000; ldurb = 1'b0; addr = 64'h40;
        for (int cyc = 0; cyc < 6; cyc++) begin
            dm_ack = 1'b0;
            #1;
            req_v[cyc] = dm_req; stall_v[cyc] = stall; done_v[cyc] = done;
            if (dm_req) begin
                dm_ack = 1'b1;
                dm_rdata = 64'h99;
            end
            @(negedge clk);
        end
        dm_ack = 1'b0; mem_read = 1'b0;
        total++; if (req_v !== 6'b010010) begin bad++; $display("[TB] FAIL b2b_req: got %b want 010010", req_v); end
        total++; if (stall_v !== 6'b011011) begin bad++; $display("[TB] FAIL b2b_stall: got %b want 011011", stall_v); end
        total++; if (done_v !== 6'b100100) begin bad++; $display("[TB] FAIL b2b_done: got %b want 100100", done_v); end
        // Let the second access's trailing IDLE pass before the next test.
        @(negedge clk);
    endtask

    task automatic test_reset_mid_req;
        mem_read = 1'b1; mem_write = 1'b0; xfer_size = 4'b1000; ldurb = 1'b0; addr = 64'h20;
        #1;
        @(negedge clk);
        mem_read = 1'b0;
        @(negedge clk);
        #1;
        total++; if (dm_req !== 1'b1 || stall !== 1'b1) begin bad++; $display("[TB] FAIL midreq_pre: got req=%b stall=%b want 11", dm_req, stall); end
        total++; if (err_sticky !== 1'b1) begin bad++; $display("[TB] FAIL midreq_sticky_pre: got %b want 1", err_sticky); end
        reset = 1'b1;
        #1;
        total++; if (dm_req !== 1'b0 || stall !== 1'b0) begin bad++; $display("[TB] FAIL midreq_async_drop: got req=%b stall=%b want 00", dm_req, stall); end
        total++; if (err_sticky !== 1'b0 || dm_addr !== 64'd0 || dm_size !== 4'd0) begin bad++; $display("[TB] FAIL midreq_reset_vals: got sticky=%b addr=%h size=%h want 0 0 0", err_sticky, dm_addr, dm_size); end
        @(negedge clk);
        reset = 1'b0;
        for (int cyc = 0; cyc < 3; cyc++) begin
            #1;
            total++; if (dm_req !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin bad++; $display("[TB] FAIL midreq_discard%0d: got req=%b done=%b err=%b want 000", cyc, dm_req, done, err); end
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; xfer_size = 4'b0000; ldurb = 1'b0;
        addr = '0; wdata = '0; dm_ack = 1'b0; dm_rdata = '0;
        test_reset();
        test_ldur();
        test_ldurb();
        test_stur_toggle();
        test_illegal();
        test_ack_race();
        test_timeout();
        test_back_to_back();
        test_reset_mid_req();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so a stuck run still terminates.
    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
